// File: rtl/sample_decimator.sv
// Sample-rate decimator: keeps every (divider+1)-th valid word, holds it in a one-entry
// valid/ready register and drops (flags) kept words the consumer is not ready for.
// Optional macro SAMPLE_DECIMATOR_OVERRUN_COUNT_EN adds a saturating dropped-sample counter.
module sample_decimator #(
    parameter int unsigned DW   = 32,
    parameter int unsigned DIVW = 24
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
    ,
    parameter int unsigned CNTW = 16
`endif
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            divider_wr,
    input  logic [DIVW-1:0] divider,
    input  logic [DW-1:0]   indata,
    input  logic            indata_valid,
    output logic [DW-1:0]   outdata,
    output logic            outdata_valid,
    input  logic            outdata_ready,
    output logic            overrun
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
    ,
    output logic [CNTW-1:0] overrun_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DIVW-1:0] div_reg;
    logic [DIVW-1:0] div_nxt;
    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] cnt_nxt;
    logic [DW-1:0]   outdata_nxt;
    logic            outdata_valid_nxt;
    logic            overrun_nxt;
    logic            restart_c;
    logic            keep_c;
    logic            drop_c;

`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
    logic [CNTW-1:0] overrun_count_nxt;
    logic [CNTW-1:0] count_base_c;
`endif

    // State register and all output/datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            div_reg       <= '0;
            cnt           <= '0;
            outdata       <= '0;
            outdata_valid <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            state         <= state_nxt;
            div_reg       <= div_nxt;
            cnt           <= cnt_nxt;
            outdata       <= outdata_nxt;
            outdata_valid <= outdata_valid_nxt;
            overrun       <= overrun_nxt;
        end
    end

    // Next-state, decimation counter, output slot and overrun logic
    always_comb begin
        state_nxt         = state;
        div_nxt           = div_reg;
        cnt_nxt           = cnt;
        outdata_nxt       = outdata;
        outdata_valid_nxt = outdata_valid;
        overrun_nxt       = overrun;
        restart_c         = 1'b0;
        keep_c            = 1'b0;
        drop_c            = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                    restart_c = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (enable) begin
            if (indata_valid) begin
                if (cnt == '0) begin
                    keep_c  = 1'b1;
                    cnt_nxt = div_reg;
                end else begin
                    cnt_nxt = cnt - DIVW'(1);
                end
            end
        end else begin
            cnt_nxt = '0;
        end

        // A divider write wins over the counter update but not over the keep decision
        if (divider_wr) begin
            div_nxt = divider;
            cnt_nxt = '0;
        end

        if (outdata_valid && outdata_ready) begin
            outdata_valid_nxt = 1'b0;
        end

        if (keep_c) begin
            if (!outdata_valid || outdata_ready) begin
                outdata_nxt       = indata;
                outdata_valid_nxt = 1'b1;
            end else begin
                drop_c = 1'b1;
            end
        end

        if (restart_c) begin
            overrun_nxt = 1'b0;
        end
        if (drop_c) begin
            overrun_nxt = 1'b1;
        end
    end

`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
    // Saturating dropped-sample counter, cleared with the sticky flag
    always_comb begin
        count_base_c      = restart_c ? '0 : overrun_count;
        overrun_count_nxt = count_base_c;
        if (drop_c && (count_base_c != '1)) begin
            overrun_count_nxt = count_base_c + CNTW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun_count <= '0;
        end else begin
            overrun_count <= overrun_count_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_sample_decimator.sv
// Scoreboard bench for sample_decimator: a cycle model pushes expected kept words,
// outputs are compared on the falling edge and words popped as the consumer accepts them.
module tb_sample_decimator;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        divider_wr;
    logic [23:0] divider;
    logic [31:0] indata;
    logic        indata_valid;
    logic [31:0] outdata;
    logic        outdata_valid;
    logic        outdata_ready;
    logic        overrun;
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
    logic [15:0] overrun_count;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    logic [31:0] exp_q[$];
    logic [23:0] m_div;
    logic [23:0] m_cnt;
    logic        m_ov;
    logic [15:0] m_ovc;
    logic        m_prev_en;

    sample_decimator dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .divider_wr   (divider_wr),
        .divider      (divider),
        .indata       (indata),
        .indata_valid (indata_valid),
        .outdata      (outdata),
        .outdata_valid(outdata_valid),
        .outdata_ready(outdata_ready),
        .overrun      (overrun)
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
        ,
        .overrun_count(overrun_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_div     = '0;
        m_cnt     = '0;
        m_ov      = 1'b0;
        m_ovc     = '0;
        m_prev_en = 1'b0;
    endtask

    // Called on a falling edge: drive, check current outputs, advance the model, wait one cycle
    task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                        input logic wr = 1'b0, input logic [23:0] dv = 24'h0);
        logic keep;
        logic rise;
        indata_valid  = v;
        indata        = d;
        outdata_ready = rdy;
        divider_wr    = wr;
        divider       = dv;

        check_val("outdata_valid", 32'(outdata_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check_val("outdata", outdata, exp_q[0]);
        end
        check_val("overrun", 32'(overrun), 32'(m_ov));
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
        check_val("overrun_count", 32'(overrun_count), 32'(m_ovc));
`endif

        rise = enable && !m_prev_en;
        keep = 1'b0;
        if (exp_q.size() != 0 && rdy) begin
            void'(exp_q.pop_front());
        end
        if (enable) begin
            if (v) begin
                if (m_cnt == 24'h0) begin
                    keep  = 1'b1;
                    m_cnt = m_div;
                end else begin
                    m_cnt = m_cnt - 24'h1;
                end
            end
        end else begin
            m_cnt = 24'h0;
        end
        if (wr) begin
            m_div = dv;
            m_cnt = 24'h0;
        end
        if (rise) begin
            m_ov  = 1'b0;
            m_ovc = 16'h0;
        end
        if (keep) begin
            if (exp_q.size() == 0) begin
                exp_q.push_back(d);
            end else begin
                m_ov = 1'b1;
                if (m_ovc != 16'hFFFF) m_ovc = m_ovc + 16'h1;
            end
        end
        m_prev_en = enable;

        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic flush(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b0;
        divider_wr    = 1'b0;
        divider       = '0;
        indata        = '0;
        indata_valid  = 1'b0;
        outdata_ready = 1'b0;
        model_reset();

        @(negedge clock);
        check_val("rst_outdata", outdata, 32'h0);
        check_val("rst_valid", 32'(outdata_valid), 32'h0);
        check_val("rst_overrun", 32'(overrun), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // divider 0: every word passes with one cycle latency
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd0);
        enable = 1'b1;
        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1);
        flush(2);

        // divider 3: keep 0x10, 0x14, 0x18
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd3);
        for (int i = 0; i < 12; i++) step(1'b1, 32'h10 + 32'(i), 1'b1);
        flush(2);

        // backpressure drops, then simultaneous drain and load
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd0);
        step(1'b1, 32'hA, 1'b0);
        step(1'b1, 32'hB, 1'b0);
        step(1'b1, 32'hC, 1'b0);
        step(1'b1, 32'hD, 1'b1);
        check_val("drain_load_valid", 32'(outdata_valid), 32'h1);
        flush(2);

        // enable toggle clears overrun; idle words ignored; first word after re-enable kept
        enable = 1'b0;
        step(1'b1, 32'h55, 1'b1);
        step(1'b1, 32'h56, 1'b1);
        enable = 1'b1;
        step(1'b1, 32'h60, 1'b1);
        step(1'b1, 32'h61, 1'b1);
        flush(2);

        // divider rewrite mid-stream
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd3);
        step(1'b1, 32'h70, 1'b1);
        step(1'b1, 32'h71, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd1);
        for (int i = 2; i < 8; i++) step(1'b1, 32'h70 + 32'(i), 1'b1);
        // write coinciding with a valid word: evaluated against the old count
        step(1'b1, 32'h78, 1'b1, 1'b1, 24'd2);
        step(1'b1, 32'h79, 1'b1);
        step(1'b1, 32'h7A, 1'b1);
        flush(2);

        // asynchronous reset with a pending word and cnt at 2
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd3);
        step(1'b1, 32'h80, 1'b0);
        step(1'b1, 32'h81, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_outdata", outdata, 32'h0);
        check_val("arst_valid", 32'(outdata_valid), 32'h0);
        check_val("arst_overrun", 32'(overrun), 32'h0);
`ifdef SAMPLE_DECIMATOR_OVERRUN_COUNT_EN
        check_val("arst_count", 32'(overrun_count), 32'h0);
`endif
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        step(1'b1, 32'h90, 1'b1);
        step(1'b1, 32'h91, 1'b1);
        flush(2);

        // largest divider: one word kept, the rest discarded
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'hFFFFFF);
        for (int i = 0; i < 6; i++) step(1'b1, 32'hA0 + 32'(i), 1'b1);
        flush(2);

        // randomised valid/ready with divider 1
        step(1'b0, 32'h0, 1'b1, 1'b1, 24'd1);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)));
        end
        flush(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sample_decimator.md
# sample_decimator

Sample-rate decimator sitting directly downstream of the 32-channel noise filter. It takes one filtered word per qualified input cycle, keeps every (divider+1)-th word, and presents kept samples on a one-entry valid/ready output register to the trigger and RLE stages. Samples that cannot be delivered because of backpressure are dropped and flagged, never stalled, because the filter stage cannot be throttled.

## Interface
- `DW`, 32, sample width in bits.
- `DIVW`, 24, divider width in bits.
- `CNTW`, 16, overrun counter width in bits; used only with the macro.

- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: 1 = run; 0 = idle, incoming words ignored.
- `divider_wr` in 1: one-cycle strobe that loads `divider`.
- `divider` in DIVW: keep one word out of every divider+1 valid words.
- `indata` in DW: filtered sample word.
- `indata_valid` in 1: `indata` is a new sample this cycle.
- `outdata` out DW: held sample.
- `outdata_valid` out 1: `outdata` holds an undelivered sample.
- `outdata_ready` in 1: the consumer accepts `outdata` this cycle.
- `overrun` out 1: sticky; at least one kept sample was dropped.
- `overrun_count` out CNTW: dropped-sample count; exists only with the macro.

## Operation
- Registers:
  - `div_reg` (DIVW)
  - down-counter `cnt` (DIVW)
  - output register `outdata`/`outdata_valid`
  - `overrun`
- States:
  - IDLE when `enable`=0.
  - RUN when `enable`=1.
  - Transition is evaluated every cycle from `enable`.
- IDLE behaviour:
  - `cnt` is forced to 0, so the first valid word after enabling is always kept.
  - Input is ignored.
  - A pending output stays until it is consumed.
- RUN behaviour, on `indata_valid`=1:
  - `cnt`==0 gives a keep event: `cnt` <= `div_reg`.
  - Otherwise `cnt` <= `cnt`-1 and the word is discarded.
- Keep event:
  - The output slot is free when `outdata_valid`=0, or when `outdata_valid`=1 and `outdata_ready`=1 in the same cycle (drain and load are simultaneous).
  - Slot free: `outdata` <= `indata` and `outdata_valid` <= 1.
  - Slot occupied: the word is dropped, the held word is unchanged, and `overrun` <= 1.
- Drain: `outdata_valid`=1 and `outdata_ready`=1 with no keep event gives `outdata_valid` <= 0.
- `divider_wr`:
  - `div_reg` <= `divider` and `cnt` <= 0 in the same cycle. The next valid word is kept, then the new ratio applies.
  - A `divider_wr` coinciding with a valid word takes priority over the counter update. That word is still evaluated against the old `cnt`.
- `overrun` clears only on `reset` or on the rising edge of `enable`.
- `divider`=0 keeps every valid word.
- `divider`=2^DIVW-1 keeps one word in 2^DIVW.
- `cnt` never wraps below 0.

## Timing
- Reset values:
  - `outdata`=0, `outdata_valid`=0, `overrun`=0, `overrun_count`=0.
  - `div_reg`=0, `cnt`=0, state IDLE.
- Latency: a kept word sampled at edge N appears on `outdata` with `outdata_valid`=1 after edge N, i.e. 1 cycle.
- Handshake rules:
  - `outdata`/`outdata_valid` are stable while valid and not ready.
  - `outdata_ready` has no combinational path to any output.
- Sustained rate: one kept word per cycle when `outdata_ready` is held at 1.
- Reset mid-operation clears all state immediately. No partial sample survives.

## Configuration
- Macro: `SAMPLE_DECIMATOR_OVERRUN_COUNT_EN`.
- Defined:
  - `overrun_count` port and register exist.
  - The counter increments on every dropped keep event and saturates at 2^CNTW-1.
  - It clears together with `overrun`.
- Undefined:
  - The port and register are absent.
  - Only the sticky `overrun` bit is provided.

## Test plan
- `divider`=0, `enable`=1, `outdata_ready`=1, valid words 0x1..0x8 on consecutive cycles -> the same 8 words out, each 1 cycle later, `overrun`=0.
- `divider`=3, 12 consecutive valid words 0x10..0x1B -> outputs 0x10, 0x14, 0x18 only.
- `divider`=0, `outdata_ready`=0, words 0xA, 0xB, 0xC -> `outdata` holds 0xA, `overrun`=1, `overrun_count`=2 (macro on).
- Then `outdata_ready`=1 with a simultaneous new word 0xD -> 0xA drained and 0xD loaded in the same cycle, `outdata_valid` stays 1.
- `divider`=3 running, `divider_wr` with `divider`=1 after the 2nd word -> the next valid word is kept, then every 2nd word.
- Assert `reset` while `outdata_valid`=1 and `cnt`=2 -> all outputs 0 immediately. After release with `enable`=1, the first valid word is kept.
- Toggle `enable` 1->0->1 with `overrun`=1 -> `overrun` and `overrun_count` clear, and the first valid word after re-enable is kept.
